fifo_wr_arbiter: RTL



---
 rtl/fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int BEAT_CNT_W = 8;

    // Increment with wrap for index spaces that need not be a power of two.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from rr_ptr, with wrap.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ producers.
//   state | meaning
//   IDLE  | no owner; any request is granted at the next edge
//   OWN   | grant_id owns the port; its beats are written while the FIFO is not full
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATASIZE  = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATASIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]           ack,
    input  logic                         fifo_full,
    output logic                         fifo_w_en,
    output logic [DATASIZE-1:0]          fifo_data_in,
    output logic                         grant_valid,
    output logic [ID_W-1:0]              grant_id,
    output logic [BEAT_CNT_W-1:0]        beat_cnt
);

    arb_state_t            state, state_d;
    logic [ID_W-1:0]       gid_q, gid_d;
    logic [BEAT_CNT_W-1:0] bc_q, bc_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_winner;
    logic                  owner_req;
    logic                  accept;
    logic                  last_beat;
    logic                  rel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .winner (pick_winner)
    );

    always_comb begin
        owner_req    = 1'b0;
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gid_q == ID_W'(i)) begin
                owner_req    = req[i];
                fifo_data_in = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    assign accept    = (state == OWN) && owner_req && !fifo_full && !rst;
    assign last_beat = accept && (bc_q == BEAT_CNT_W'(MAX_BURST - 1));
    // A full FIFO stalls the owner without releasing it; only a dropped req or a full burst releases.
    assign rel       = (state == OWN) && (!owner_req || last_beat);

    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = accept && (gid_q == ID_W'(i));
        end
    end

    assign fifo_w_en = accept;

    always_comb begin
        state_d  = state;
        gid_d    = gid_q;
        bc_d     = bc_q;
        rr_ptr_d = rr_ptr_q;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d  = OWN;
                    gid_d    = pick_winner;
                    bc_d     = '0;
                    rr_ptr_d = ID_W'(next_idx(32'(pick_winner), NUM_REQ));
                end
            end
            OWN: begin
                if (rel) begin
                    bc_d = '0;
                    if (pick_found) begin
                        gid_d    = pick_winner;
                        rr_ptr_d = ID_W'(next_idx(32'(pick_winner), NUM_REQ));
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    bc_d = bc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gid_q    <= '0;
            bc_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state    <= state_d;
            gid_q    <= gid_d;
            bc_q     <= bc_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_valid = (state == OWN);
    assign grant_id    = gid_q;
    assign beat_cnt    = bc_q;

endmodule
